// File: rtl/multi_cycle_controller_if.sv
// Handshake and control bundle between the multi-cycle controller and its datapath/memories.
interface multi_cycle_controller_if;
  logic [31:0] Instr;
  logic        BrTaken;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic [2:0]  ImmSel;
  logic        IRWrite;
  logic        PCWrite;
  logic [1:0]  PCSel;
  logic        RegWrite;
  logic [1:0]  WBSel;
  logic        trap;
  logic [1:0]  trap_cause;

  // The controller issues memory requests and datapath strobes.
  modport master (
    input  Instr, BrTaken, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ImmSel, IRWrite, PCWrite,
           PCSel, RegWrite, WBSel, trap, trap_cause
  );

  // The datapath/memory side answers the controller.
  modport slave (
    output Instr, BrTaken, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ImmSel, IRWrite, PCWrite,
           PCSel, RegWrite, WBSel, trap, trap_cause
  );
endinterface

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with handshake timeouts and a sticky TRAP.
module multi_cycle_controller #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multi_cycle_controller_if.master  ctrl
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT = CW'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_FENCE
  } opClass_t;

  state_t        r_state;
  state_t        w_nextState;
  opClass_t      r_class;
  opClass_t      w_decClass;
  logic [2:0]    r_immSel;
  logic [2:0]    w_decImm;
  logic          w_decLegal;
  logic [CW-1:0] r_waitCnt;
  logic [1:0]    r_trapCause;
  logic [1:0]    w_nextCause;
  logic          w_waiting;
  logic          w_timeout;
  logic          w_unusedInstr;

  assign w_unusedInstr = ^ctrl.Instr[31:7];

  // Opcode decoder: instruction class and immediate format for the current IR.
  always_comb begin
    w_decLegal = 1'b1;
    w_decClass = C_ALU;
    w_decImm   = 3'b111;
    case (ctrl.Instr[6:0])
      7'b0000011: begin w_decClass = C_LOAD;   w_decImm = 3'b000; end
      7'b0010011: begin w_decClass = C_ALU;    w_decImm = 3'b000; end
      7'b1100111: begin w_decClass = C_JALR;   w_decImm = 3'b000; end
      7'b0100011: begin w_decClass = C_STORE;  w_decImm = 3'b001; end
      7'b1100011: begin w_decClass = C_BRANCH; w_decImm = 3'b010; end
      7'b1101111: begin w_decClass = C_JAL;    w_decImm = 3'b011; end
      7'b0110111,
      7'b0010111: begin w_decClass = C_ALU;    w_decImm = 3'b100; end
      7'b0110011: begin w_decClass = C_ALU;    w_decImm = 3'b111; end
      7'b0001111: begin w_decClass = C_FENCE;  w_decImm = 3'b111; end
      default:    w_decLegal = 1'b0;
    endcase
  end

  assign w_waiting = ((r_state == S_FETCH) && !ctrl.imem_ready) ||
                     ((r_state == S_MEM)   && !ctrl.dmem_ready);
  assign w_timeout = w_waiting && (r_waitCnt == TIMEOUT);

  // Wait counter: counts stalled handshake cycles, zero whenever no handshake is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt <= '0;
    end else if (w_waiting && !w_timeout) begin
      r_waitCnt <= r_waitCnt + CW'(1);
    end else begin
      r_waitCnt <= '0;
    end
  end

  // State, latched instruction class, ImmSel and trap cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_class     <= C_ALU;
      r_immSel    <= 3'b000;
      r_trapCause <= 2'b00;
    end else begin
      r_state     <= w_nextState;
      r_trapCause <= w_nextCause;
      if ((r_state == S_DECODE) && w_decLegal) begin
        r_class  <= w_decClass;
        r_immSel <= w_decImm;
      end
    end
  end

  // Next-state and strobe logic; everything stays quiet while reset is held.
  always_comb begin
    w_nextState   = r_state;
    w_nextCause   = r_trapCause;
    ctrl.imem_req = 1'b0;
    ctrl.dmem_req = 1'b0;
    ctrl.dmem_we  = 1'b0;
    ctrl.IRWrite  = 1'b0;
    ctrl.PCWrite  = 1'b0;
    ctrl.PCSel    = 2'b00;
    ctrl.RegWrite = 1'b0;
    ctrl.WBSel    = 2'b00;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          ctrl.imem_req = 1'b1;
          if (ctrl.imem_ready) begin
            ctrl.IRWrite = 1'b1;
            w_nextState  = S_DECODE;
          end else if (w_timeout) begin
            w_nextState = S_TRAP;
            w_nextCause = 2'b10;
          end
        end
        S_DECODE: begin
          if (w_decLegal) begin
            w_nextState = S_EXEC;
          end else begin
            w_nextState = S_TRAP;
            w_nextCause = 2'b01;
          end
        end
        S_EXEC: begin
          case (r_class)
            C_BRANCH: begin
              ctrl.PCWrite = 1'b1;
              ctrl.PCSel   = ctrl.BrTaken ? 2'b01 : 2'b00;
              w_nextState  = S_FETCH;
            end
            C_FENCE: begin
              ctrl.PCWrite = 1'b1;
              w_nextState  = S_FETCH;
            end
            C_LOAD, C_STORE: w_nextState = S_MEM;
            default:         w_nextState = S_WB;
          endcase
        end
        S_MEM: begin
          ctrl.dmem_req = 1'b1;
          ctrl.dmem_we  = (r_class == C_STORE);
          if (ctrl.dmem_ready) begin
            if (r_class == C_STORE) begin
              ctrl.PCWrite = 1'b1;
              w_nextState  = S_FETCH;
            end else begin
              w_nextState = S_WB;
            end
          end else if (w_timeout) begin
            w_nextState = S_TRAP;
            w_nextCause = 2'b11;
          end
        end
        S_WB: begin
          ctrl.RegWrite = 1'b1;
          ctrl.PCWrite  = 1'b1;
          case (r_class)
            C_LOAD: ctrl.WBSel = 2'b01;
            C_JAL: begin
              ctrl.WBSel = 2'b10;
              ctrl.PCSel = 2'b01;
            end
            C_JALR: begin
              ctrl.WBSel = 2'b10;
              ctrl.PCSel = 2'b10;
            end
            default: ctrl.WBSel = 2'b00;
          endcase
          w_nextState = S_FETCH;
        end
        S_TRAP:  w_nextState = S_TRAP;
        default: w_nextState = S_FETCH;
      endcase
    end
  end

  assign ctrl.ImmSel     = r_immSel;
  assign ctrl.trap       = (r_state == S_TRAP);
  assign ctrl.trap_cause = r_trapCause;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized self-checking bench: a transaction-level model expands each instruction into
// its expected per-cycle control outputs, and one compare process checks them every cycle.
module tb_multi_cycle_controller;

  localparam int TO = 4;

  localparam int K_ALU    = 0;
  localparam int K_LOAD   = 1;
  localparam int K_STORE  = 2;
  localparam int K_BRANCH = 3;
  localparam int K_JAL    = 4;
  localparam int K_JALR   = 5;
  localparam int K_FENCE  = 6;
  localparam int K_ILL    = 7;

  typedef struct {
    logic       imemReq;
    logic       dmemReq;
    logic       dmemWe;
    logic [2:0] immSel;
    logic       chkImm;
    logic       irWrite;
    logic       pcWrite;
    logic [1:0] pcSel;
    logic       regWrite;
    logic [1:0] wbSel;
    logic       trap;
    logic [1:0] cause;
    int         cyc;
  } expT;

  logic clock;
  logic rst_n;

  multi_cycle_controller_if bus ();

  multi_cycle_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk   (clock),
    .rst_n (rst_n),
    .ctrl  (bus.master)
  );

  int         assertions = 0;
  int         failures   = 0;
  int         cycleNo    = 0;
  int         dmemHigh   = 0;
  logic [2:0] modelImm   = 3'b000;
  expT        expQ[$];
  expT        cmpE;
  logic       cmpBad;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single compare process: every cycle with a model expectation is checked at the falling edge.
  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      cmpE = expQ.pop_front();
      cmpBad = (bus.imem_req !== cmpE.imemReq) || (bus.dmem_req !== cmpE.dmemReq) ||
               (bus.IRWrite !== cmpE.irWrite) || (bus.PCWrite !== cmpE.pcWrite) ||
               (bus.RegWrite !== cmpE.regWrite) || (bus.trap !== cmpE.trap) ||
               (bus.trap_cause !== cmpE.cause) ||
               (cmpE.dmemReq && (bus.dmem_we !== cmpE.dmemWe)) ||
               (cmpE.pcWrite && (bus.PCSel !== cmpE.pcSel)) ||
               (cmpE.regWrite && (bus.WBSel !== cmpE.wbSel)) ||
               (cmpE.chkImm && (bus.ImmSel !== cmpE.immSel));
      assertions++;
      if (cmpBad) begin
        failures++;
        $display("[TB] FAIL cycle%0d outputs: actual ireq=%b dreq=%b we=%b imm=%b ir=%b pcw=%b pcs=%b rw=%b wbs=%b trap=%b cause=%b; required ireq=%b dreq=%b we=%b imm=%b ir=%b pcw=%b pcs=%b rw=%b wbs=%b trap=%b cause=%b",
                 cmpE.cyc, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ImmSel, bus.IRWrite,
                 bus.PCWrite, bus.PCSel, bus.RegWrite, bus.WBSel, bus.trap, bus.trap_cause,
                 cmpE.imemReq, cmpE.dmemReq, cmpE.dmemWe, cmpE.immSel, cmpE.irWrite,
                 cmpE.pcWrite, cmpE.pcSel, cmpE.regWrite, cmpE.wbSel, cmpE.trap, cmpE.cause);
      end
    end
    if (bus.dmem_req === 1'b1) dmemHigh++;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int classOf(input logic [6:0] op);
    case (op)
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BRANCH;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0001111: return K_FENCE;
      7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111: return K_ALU;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] immOf(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  function automatic expT idleExp();
    expT e;
    e.imemReq  = 1'b0;
    e.dmemReq  = 1'b0;
    e.dmemWe   = 1'b0;
    e.immSel   = modelImm;
    e.chkImm   = 1'b1;
    e.irWrite  = 1'b0;
    e.pcWrite  = 1'b0;
    e.pcSel    = 2'b00;
    e.regWrite = 1'b0;
    e.wbSel    = 2'b00;
    e.trap     = 1'b0;
    e.cause    = 2'b00;
    e.cyc      = 0;
    return e;
  endfunction

  task automatic checkVal(input string name, input int act, input int req);
    assertions++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, and advance to just after the next edge.
  task automatic applyStimulus(input logic ir, input logic dr, input logic br, input expT e);
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    bus.BrTaken    = br;
    e.cyc = cycleNo;
    cycleNo++;
    expQ.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput();
    checkVal("reset imem_req", int'(bus.imem_req), 0);
    checkVal("reset dmem_req", int'(bus.dmem_req), 0);
    checkVal("reset strobes", int'({bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.dmem_we}), 0);
    checkVal("reset ImmSel", int'(bus.ImmSel), 0);
    checkVal("reset PCSel/WBSel", int'({bus.PCSel, bus.WBSel}), 0);
    checkVal("reset trap", int'({bus.trap, bus.trap_cause}), 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput();
    @(posedge clock);
    @(posedge clock);
    #1;
    rst_n    = 1'b1;
    modelImm = 3'b000;
  endtask

  task automatic enterTrap(input logic [1:0] cause);
    expT e;
    for (int k = 0; k < 3; k++) begin
      e = idleExp();
      e.chkImm = 1'b0;
      e.trap   = 1'b1;
      e.cause  = cause;
      applyStimulus(rbit(), rbit(), rbit(), e);
    end
    doReset();
  endtask

  // Model of one instruction: iw/dw are the wait states before imem/dmem ready.
  task automatic runInstr(input logic [31:0] instr, input int iw, input int dw, input logic br,
                          input int abortMem, output int cycles);
    expT  e;
    int   cls;
    logic done;
    cycles = 0;
    done   = 1'b0;
    for (int k = 0; k <= TO && !done; k++) begin
      e = idleExp();
      e.imemReq = 1'b1;
      if (k >= iw) begin
        e.irWrite = 1'b1;
        applyStimulus(1'b1, rbit(), rbit(), e);
        done = 1'b1;
      end else begin
        applyStimulus(1'b0, rbit(), rbit(), e);
      end
      cycles++;
    end
    if (!done) begin
      enterTrap(2'b10);
      return;
    end
    bus.Instr = instr;
    cls = classOf(instr[6:0]);
    e = idleExp();
    e.chkImm = 1'b0;
    applyStimulus(rbit(), rbit(), rbit(), e);
    cycles++;
    if (cls == K_ILL) begin
      enterTrap(2'b01);
      return;
    end
    modelImm = immOf(instr[6:0]);
    e = idleExp();
    if (cls == K_BRANCH || cls == K_FENCE) begin
      e.pcWrite = 1'b1;
      e.pcSel   = (cls == K_BRANCH && br) ? 2'b01 : 2'b00;
      applyStimulus(rbit(), rbit(), br, e);
      cycles++;
      return;
    end
    applyStimulus(rbit(), rbit(), rbit(), e);
    cycles++;
    if (cls == K_LOAD || cls == K_STORE) begin
      done = 1'b0;
      for (int k = 0; k <= TO && !done; k++) begin
        if (abortMem > 0 && k == abortMem) begin
          bus.dmem_ready = 1'b0;
          #1;
          checkVal("pre-reset dmem_req", int'(bus.dmem_req), 1);
          rst_n = 1'b0;
          #1;
          checkOutput();
          @(posedge clock);
          #1;
          rst_n    = 1'b1;
          modelImm = 3'b000;
          return;
        end
        e = idleExp();
        e.dmemReq = 1'b1;
        e.dmemWe  = (cls == K_STORE);
        if (k >= dw) begin
          if (cls == K_STORE) begin
            e.pcWrite = 1'b1;
            e.pcSel   = 2'b00;
          end
          applyStimulus(rbit(), 1'b1, rbit(), e);
          done = 1'b1;
        end else begin
          applyStimulus(rbit(), 1'b0, rbit(), e);
        end
        cycles++;
      end
      if (!done) begin
        enterTrap(2'b11);
        return;
      end
      if (cls == K_STORE) return;
    end
    e = idleExp();
    e.regWrite = 1'b1;
    e.pcWrite  = 1'b1;
    e.wbSel    = (cls == K_LOAD) ? 2'b01 : ((cls == K_JAL || cls == K_JALR) ? 2'b10 : 2'b00);
    e.pcSel    = (cls == K_JAL) ? 2'b01 : ((cls == K_JALR) ? 2'b10 : 2'b00);
    applyStimulus(rbit(), rbit(), rbit(), e);
    cycles++;
  endtask

  function automatic int pickWait();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 16) return r % 4;
    if (r < 18) return TO;
    return TO + 1;
  endfunction

  logic [6:0] opTable [12] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                               7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111,
                               7'b0110011, 7'b0001111, 7'b0000000, 7'b1111111};

  initial begin
    int          cyc;
    logic [31:0] rnd;
    logic [31:0] instr;
    int          sel;
    rst_n          = 1'b0;
    bus.Instr      = 32'h0;
    bus.BrTaken    = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    @(posedge clock);
    #1;
    checkOutput();
    @(posedge clock);
    #1;
    rst_n = 1'b1;

    runInstr(32'h00500093, 0, 0, 1'b0, 0, cyc);
    checkVal("ADDI cycles", cyc, 4);
    checkVal("ADDI ImmSel", int'(bus.ImmSel), 0);

    dmemHigh = 0;
    runInstr(32'h0000A103, 0, 3, 1'b0, 0, cyc);
    checkVal("LW cycles", cyc, 8);
    checkVal("LW dmem_req cycles", dmemHigh, 4);

    runInstr(32'h00000463, 0, 0, 1'b1, 0, cyc);
    checkVal("BEQ taken cycles", cyc, 3);
    checkVal("BEQ ImmSel", int'(bus.ImmSel), 2);
    runInstr(32'h00000463, 0, 0, 1'b0, 0, cyc);
    checkVal("BEQ not-taken cycles", cyc, 3);

    runInstr(32'h0020A023, 0, 0, 1'b0, 0, cyc);
    checkVal("SW cycles", cyc, 4);
    checkVal("SW ImmSel", int'(bus.ImmSel), 1);
    runInstr(32'h0000100F, 0, 0, 1'b0, 0, cyc);
    checkVal("FENCE cycles", cyc, 3);
    runInstr(32'h008000EF, 0, 0, 1'b0, 0, cyc);
    checkVal("JAL ImmSel", int'(bus.ImmSel), 3);

    runInstr(32'h0020A023, 0, 99, 1'b0, 2, cyc);
    runInstr(32'h00500093, TO, 0, 1'b0, 0, cyc);
    checkVal("ready-wins cycles", cyc, TO + 4);
    runInstr(32'h00500093, TO + 1, 0, 1'b0, 0, cyc);
    runInstr(32'h00000000, 0, 0, 1'b0, 0, cyc);
    runInstr(32'h0000A103, 0, TO + 1, 1'b0, 0, cyc);

    for (int n = 0; n < 200; n++) begin
      rnd   = $urandom();
      sel   = int'($urandom_range(0, 100)) < 4 ? 10 + int'($urandom_range(0, 1))
                                               : int'($urandom_range(0, 9));
      instr = {rnd[31:7], opTable[sel]};
      runInstr(instr, pickWait(), pickWait(), rbit(), 0, cyc);
    end

    @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, giving the maximum wait cycles on any memory handshake before a trap.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port Instr, input, 32 bits: instruction register contents from the datapath.
REQ-005 SHALL have port BrTaken, input, 1 bit: branch comparator result for the current instruction.
REQ-006 SHALL have port imem_ready, input, 1 bit: instruction memory data valid.
REQ-007 SHALL have port dmem_ready, input, 1 bit: data memory access complete.
REQ-008 SHALL have port imem_req, output, 1 bit: instruction fetch request.
REQ-009 SHALL have port dmem_req, output, 1 bit: data memory request.
REQ-010 SHALL have port dmem_we, output, 1 bit: data memory write when dmem_req=1.
REQ-011 SHALL have port ImmSel, output, 3 bits: immediate generator format select (I=000, S=001, B=010, J=011, U=100, none=111).
REQ-012 SHALL have port IRWrite, output, 1 bit: instruction register load.
REQ-013 SHALL have port PCWrite, output, 1 bit: PC update.
REQ-014 SHALL have port PCSel, output, 2 bits: PC source (00 PC+4, 01 PC+Imm, 10 (rs1+Imm)&~1).
REQ-015 SHALL have port RegWrite, output, 1 bit: register file write.
REQ-016 SHALL have port WBSel, output, 2 bits: writeback source (00 ALU, 01 memory, 10 PC+4).
REQ-017 SHALL have port trap, output, 1 bit: sticky fault flag.
REQ-018 SHALL have port trap_cause, output, 2 bits: fault cause (01 illegal opcode, 10 imem timeout, 11 dmem timeout).

Function
REQ-019 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-020 FETCH SHALL hold imem_req=1 until imem_ready=1; on that cycle it SHALL pulse IRWrite=1 for one cycle and go to DECODE.
REQ-021 DECODE SHALL last one cycle, register ImmSel from Instr[6:0], and go to EXEC; an unknown opcode SHALL go to TRAP with cause 01.
REQ-022 The opcode-to-ImmSel mapping SHALL be:
- LOAD, OP-IMM, JALR -> 000
- STORE -> 001
- BRANCH -> 010
- JAL -> 011
- LUI, AUIPC -> 100
- OP, FENCE -> 111
REQ-023 ImmSel SHALL hold its DECODE value until the next DECODE.
REQ-024 EXEC for BRANCH SHALL assert PCWrite=1 with PCSel=01 if BrTaken=1, else 00, and go to FETCH (3 cycles at zero wait).
REQ-025 EXEC for FENCE SHALL assert PCWrite=1 with PCSel=00 and go to FETCH.
REQ-026 EXEC for LOAD and STORE SHALL go to MEM; for all other opcodes it SHALL go to WB.
REQ-027 MEM SHALL hold dmem_req=1 (dmem_we=1 for STORE) until dmem_ready=1.
REQ-028 On dmem_ready, a LOAD SHALL go to WB; a STORE SHALL assert PCWrite=1 with PCSel=00 and go to FETCH.
REQ-029 WB SHALL assert RegWrite=1 and PCWrite=1 for one cycle, then go to FETCH, with:
- WBSel = 01 for LOAD, 10 for JAL/JALR, 00 otherwise
- PCSel = 01 for JAL, 10 for JALR, 00 otherwise
REQ-030 Latency at zero wait states SHALL be: ALU/LUI/AUIPC/JAL/JALR 4 cycles, STORE 4, LOAD 5, BRANCH 3, FENCE 3.
REQ-031 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle the ready input is low.
REQ-032 When the wait counter reaches MEM_TIMEOUT with ready still low, the FSM SHALL go to TRAP with cause 10 (FETCH) or 11 (MEM).
REQ-033 If ready and the timeout condition occur in the same cycle, ready SHALL win.
REQ-034 TRAP SHALL be absorbing: trap=1, cause held, all strobe and request outputs 0, until reset.
REQ-035 PCWrite, RegWrite, IRWrite, imem_req and dmem_req SHALL never be asserted in TRAP or while rst_n=0.

Reset
REQ-036 Assertion of rst_n=0 SHALL immediately force:
- state to FETCH
- all strobes and requests to 0
- ImmSel to 000, PCSel and WBSel to 00
- trap and trap_cause to 0
- wait counter to 0
REQ-037 An in-flight memory request SHALL be abandoned on reset.
REQ-038 The first imem_req SHALL occur in the first cycle after rst_n rises.

Verification
REQ-039 Instr=0x00500093 (ADDI x1,x0,5), zero wait -> ImmSel=000, RegWrite and PCWrite high in cycle 4 with WBSel=00, PCSel=00.
REQ-040 Instr=0x0000A103 (LW x2,0(x1)), dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then RegWrite with WBSel=01; 8 cycles total.
REQ-041 Instr=0x00000463 (BEQ, +8) with BrTaken=1, then with BrTaken=0 -> ImmSel=010, PCWrite in cycle 3 with PCSel=01, then 00; RegWrite never asserted.
REQ-042 Instr=0x00000000 -> trap=1, trap_cause=01 after DECODE; no further imem_req until reset.
REQ-043 imem_ready held low with MEM_TIMEOUT=4 -> trap_cause=10 after 4 wait cycles; ready rising in the same cycle as the timeout -> no trap.
REQ-044 rst_n pulsed low during MEM of a STORE -> dmem_req drops asynchronously; after release the next cycle is FETCH with imem_req=1.
